// File: rtl/blink_rate_regs_if.sv
// Processor register-slot bus for blink_rate_regs.
// Carries select, strobes, address and data.
interface blink_rate_regs_if;
  logic        cs;
  logic        write;
  logic        read;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, write, read, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, write, read, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/blink_rate_regs.sv
// Staged blink-period registers with aligned commit for four LED channels.
// BLINK_RATE_REGS_READBACK_EN enables readback of STAGE0..3 and CTRL.
module blink_rate_regs #(
  parameter logic [15:0] DEFAULT_PERIOD = 16'd500,
  parameter int          CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  blink_rate_regs_if.slave   bus,
  input  logic               sync_tick,
  output logic [15:0]        reg_out0,
  output logic [15:0]        reg_out1,
  output logic [15:0]        reg_out2,
  output logic [15:0]        reg_out3,
  output logic               pending
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    APPLY
  } state_t;

  state_t state_q, state_d;

  logic [15:0]      stage_q  [4];
  logic [15:0]      active_q [4];
  logic [3:0]       en_mask_q;
  logic             sync_mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rd_q;
  logic [31:0]      rd_mux;
  logic [7:0]       cnt8;
  logic             wr, rd;
  logic             stage_wr, ctrl_wr, commit;
  logic             unused_bits;

  assign wr       = bus.cs & bus.write;
  assign rd       = bus.cs & bus.read;
  assign stage_wr = wr & ~bus.addr[2];
  assign ctrl_wr  = wr & (bus.addr == 3'd4);
  assign commit   = ctrl_wr & bus.wr_data[0];

  assign pending  = (state_q == WAIT_SYNC);
  assign cnt8     = 8'(cnt_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SYNC: begin
        if (sync_tick) state_d = APPLY;
      end
      default: begin
        // APPLY accepts a new commit exactly like IDLE
        state_d = IDLE;
        if (commit)
          state_d = bus.wr_data[1] ? WAIT_SYNC : APPLY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
`ifdef BLINK_RATE_REGS_READBACK_EN
      3'd0, 3'd1, 3'd2, 3'd3:
        rd_mux = {16'h0, stage_q[bus.addr[1:0]]};
      3'd4:
        rd_mux = {24'h0, en_mask_q, 2'b0, sync_mode_q, 1'b0};
`endif
      3'd5:
        rd_mux = {16'h0, cnt8, en_mask_q, 3'b0, pending};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        stage_q[i]  <= DEFAULT_PERIOD;
        active_q[i] <= DEFAULT_PERIOD;
      end
      en_mask_q   <= 4'hF;
      sync_mode_q <= 1'b0;
      cnt_q       <= '0;
      rd_q        <= '0;
    end else begin
      if (stage_wr)
        stage_q[bus.addr[1:0]] <= bus.wr_data[15:0];
      if (ctrl_wr) begin
        en_mask_q   <= bus.wr_data[7:4];
        sync_mode_q <= bus.wr_data[1];
      end
      // ACTIVE loads the pre-write STAGE value
      if (state_q == APPLY) begin
        for (int i = 0; i < 4; i++)
          active_q[i] <= stage_q[i];
        cnt_q <= cnt_q + 1'b1;
      end
      if (rd)
        rd_q <= rd_mux;
    end
  end

  assign bus.rd_data = rd_q;

  assign reg_out0 = en_mask_q[0] ? active_q[0] : 16'h0;
  assign reg_out1 = en_mask_q[1] ? active_q[1] : 16'h0;
  assign reg_out2 = en_mask_q[2] ? active_q[2] : 16'h0;
  assign reg_out3 = en_mask_q[3] ? active_q[3] : 16'h0;

  assign unused_bits = ^{bus.wr_data[31:16],
                         bus.wr_data[3:2],
                         sync_mode_q};

endmodule

// File: doc/blink_rate_regs.md
Name: blink_rate_regs

Overview:
- Processor-facing register slot that supplies the four 16-bit blink-period words to the four-channel blinking LED top (reg_in0..reg_in3).
- Software writes per-channel periods into staging registers, then commits them, either immediately or at the next sync_tick. All four channels change on the same clock edge, so LED phases stay aligned.
- Also provides a per-channel enable mask and a status/commit counter for software.

Parameters:
- DEFAULT_PERIOD, 16'd500: reset value of every staging and active period register.
- CNT_W, 8: width of commit_count (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cs  in  1  slot select; write/read ignored when 0
- write  in  1  write strobe, qualified by cs, sampled on clk edge
- read  in  1  read strobe, qualified by cs
- addr  in  3  register index
- wr_data  in  32  write data
- rd_data  out  32  registered read data
- sync_tick  in  1  single-cycle alignment pulse from upstream tick generator
- reg_out0..reg_out3  out  16 each  active period to blink channels 0..3
- pending  out  1  high while a commit is waiting for sync_tick

Behaviour:
- Register map:
  - addr 0-3: STAGE0..3, W: wr_data[15:0]; R: staged value.
  - addr 4: CTRL, W: bit0 commit (self-clearing, not stored), bit1 sync_mode, bits[7:4] en_mask; R: {24'b0, en_mask, 2'b0, sync_mode, 1'b0}.
  - addr 5: STATUS, R only: {commit_count zero-extended to [15:8], en_mask[7:4], 3'b0, pending}. Writes ignored.
  - addr 6-7: read 0, writes ignored.
- Reset values (async, reset==0):
  - STAGEn and ACTIVEn = DEFAULT_PERIOD; en_mask = 4'hF; sync_mode = 0; commit_count = 0; state = IDLE; rd_data = 0; pending = 0.
- reg_outN = en_mask[N] ? ACTIVEn : 16'h0000. This is combinational from registers; 0 means the channel is off downstream.
- A CTRL write updates en_mask and sync_mode on the write edge. en_mask takes effect immediately, without commit.
- FSM states: IDLE, WAIT_SYNC, APPLY.
  - IDLE: a CTRL write with bit0=1 goes to APPLY if the new sync_mode is 0, or to WAIT_SYNC if it is 1.
  - WAIT_SYNC: sync_tick==1 goes to APPLY. A sync_tick on the same edge as the commit write is not used; the FSM waits for the next tick. Further commit writes are ignored. pending = 1 only in this state.
  - APPLY: one cycle. On the next edge, ACTIVEn <= STAGEn for all n, commit_count increments (wraps), and the FSM goes to IDLE. A commit write sampled during APPLY is honoured as if the FSM were in IDLE (goes to APPLY or WAIT_SYNC).
- Latency:
  - Immediate mode: commit write at edge E0 gives reg_out update at E1.
  - Sync mode: tick sampled at edge Es gives update at Es+1.
- Staging writes during WAIT_SYNC or APPLY are legal. ACTIVE takes the STAGE value present at the APPLY edge. A write on that same edge is not applied, because ACTIVE loads the pre-write value.
- Reads: rd_data <= mux(addr) on an edge where cs&read is high; otherwise rd_data holds. One-cycle read latency.
- Write and read in the same cycle: rd_data returns the pre-write value.
- Reset mid-WAIT_SYNC: the pending commit is discarded, and outputs return to DEFAULT_PERIOD with en_mask F.

Optional Feature:
- Macro: BLINK_RATE_REGS_READBACK_EN.
- Defined: addresses 0-3 and 4 read back as in the map.
- Undefined: addresses 0-4 read 32'h0, and STATUS (addr 5) remains readable. This saves the 32-bit read mux on area-tight builds.

Test Plan:
- Reset, then release: reg_out0..3 = 500, pending = 0, STATUS read = 32'h0000_00F0.
- Write STAGE2 = 16'd100, CTRL = 32'h0000_00F1: reg_out2 = 100 exactly one edge after the CTRL write; commit_count = 1; other channels stay 500.
- CTRL = 32'h0000_00F3 (sync mode), then 20 idle cycles, then a sync_tick pulse: pending = 1 for the whole wait; reg_out changes one edge after the tick; pending = 0 afterwards. A second commit issued during the wait leaves commit_count at +1 only.
- CTRL = 32'h0000_0050: reg_out1 and reg_out3 = 0 on the next edge; reg_out0 and reg_out2 keep their values; no commit_count change.
- 256 immediate commits: commit_count wraps to 0; STATUS[15:8] = 8'h00.
- Assert reset while pending = 1: outputs = 500 and pending = 0 asynchronously; a later sync_tick causes no update.
